fifo_ext: RTL
=============

# fifo_ext

Parametrised synchronous FIFO: the next-generation single-clock buffer for the data paths between streaming blocks. It adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through read mode, programmable almost-full and almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags. One clock domain; the block drops into any producer/consumer path that today uses the basic FIFO.

## Interface
- WIDTH, 24, data word width in bits (≥1)
- DEPTH, 16, number of storable words; any integer ≥2, power of two not required
- FWFT, 0, read mode: 0 = registered read (data one cycle after rd), 1 = first-word-fall-through
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr  in  1  write request
- rd  in  1  read request
- din  in  WIDTH  write data
- clr_err  in  1  clears overflow/underflow (synchronous)
- dout  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH+1)  number of stored words
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read hit an empty FIFO

## Operation
- Storage: DEPTH×WIDTH array. The read and write pointers are $clog2(DEPTH) bits and wrap explicitly from DEPTH-1 to 0; wrap does not rely on natural overflow.
- Status outputs (full, empty, almost_*) decode combinationally from the count register only.
- Write accepted when wr & (~full | rd_accepted): stores din at wr_ptr, and wr_ptr advances.
- Read accepted when rd & ~empty: rd_ptr advances.
- count: +1 on accepted write without accepted read; −1 on accepted read without accepted write; otherwise unchanged. It never leaves 0..DEPTH.
- Full with rd & wr: both are accepted and count stays DEPTH.
- FWFT=0:
  - dout is a register.
  - On an accepted read, dout <= mem[rd_ptr].
  - rd & wr while empty: bypass, with dout <= din. Nothing is stored, count stays 0, no underflow.
  - Otherwise dout holds.
- FWFT=1:
  - dout = mem[rd_ptr] combinationally; valid whenever ~empty.
  - rd acknowledges (pops) the word currently shown.
  - rd & wr while empty: the write is accepted, the read is rejected and flags underflow.
- overflow set by wr & full & ~rd. underflow set by rd & empty, except for the FWFT=0 bypass case. Both flags stay set until clr_err or rst.
- clr_err in the same cycle as a new error: the error wins and the flag stays 1.
- Rejected operations change no pointer, no count and no memory.

## Timing
- Reset values: count=0, pointers=0, dout=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0, i.e. 0 for legal values), overflow=0, underflow=0. Memory contents are not reset.
- rst mid-stream overrides wr, rd and clr_err in the same cycle; all contents are discarded.
- Status flags and count reflect an operation on the clock edge after it.
- FWFT=0 read latency: dout valid 1 cycle after the rd edge.
- FWFT=1 write-to-visible latency: a word written into an empty FIFO appears on dout and empty falls 1 cycle after the wr edge.
- Back-to-back rd/wr every cycle is sustained at full throughput in both modes.

## Test plan
- DEPTH=5, FWFT=0, AF_LEVEL=4, AE_LEVEL=1. Write 0x01..0x05 on consecutive cycles:
  - almost_empty falls after the 2nd write, almost_full rises after the 4th, full rises after the 5th, count=5.
  - A 6th write 0x06 with rd=0 is dropped and overflow=1.
- Continuing from the previous scenario, read 5 times: dout = 0x01..0x05, each one cycle after its rd. Then empty=1 and count=0. A further rd sets underflow=1 and dout holds 0x05.
- Wrap with DEPTH=5: run 12 interleaved write/read pairs with data 0x10..0x1B. The output sequence must match the input order, confirming the pointer wrap at 4→0. count never exceeds 1.
- FWFT=0, empty, rd=wr=1 with din=0xAB: next cycle dout=0xAB, count=0, empty=1, underflow=0. Full, rd=wr=1 with din=0xCD: count stays 5, overflow unchanged, 0xCD is read out last.
- FWFT=1: write 0x33 into empty → next cycle empty=0 and dout=0x33 without rd. Then rd: empty=1 the following cycle. Then rd=wr=1 while empty: the write is stored, underflow=1.
- With overflow=1, assert clr_err → overflow=0 next cycle. Assert clr_err together with a write to a full FIFO → overflow stays 1. Assert rst mid-fill (count=3) → all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/fifo_ext.sv
// Single-clock FIFO with arbitrary depth, registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, fill level and sticky error flags.
module fifo_ext #(
    parameter int WIDTH    = 24,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [WIDTH-1:0]           din,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic bypass;
    logic rd_ok;
    logic wr_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Registered mode forwards din straight to dout when reading and writing an empty FIFO.
    assign bypass = (FWFT == 0) && rd && wr && empty;
    assign rd_ok  = rd && !empty;
    assign wr_ok  = wr && (!full || rd_ok) && !bypass;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // A fresh error in the clearing cycle takes priority over the clear.
        if (wr && full && !rd) overflow_d = 1'b1;
        if (rd && empty && !bypass) underflow_d = 1'b1;
        if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (wr_ok && !rd_ok) count_d = count_q + CW'(1);
        else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wr_ptr_q] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = mem[rd_ptr_q];
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst)        dout_q <= '0;
                else if (bypass) dout_q <= din;
                else if (rd_ok)  dout_q <= mem[rd_ptr_q];
            end
            assign dout = dout_q;
        end
    endgenerate
endmodule
